// File: rtl/nibble_bist_pkg.sv
// Shared types and defaults for the nibble adder self-test initiator.
package nibble_bist_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_ERR_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } bist_state_e;

   typedef struct packed {
      logic                 valid;
      logic [DEF_WIDTH-1:0] exp;
      logic [DEF_WIDTH-1:0] a;
      logic [DEF_WIDTH-1:0] b;
   } pipe_entry_t;

endpackage

// File: rtl/bist_expect_pipe.sv
// Expected-result delay line; each entry surfaces at the tail exactly LATENCY
// edges after it was pushed, lining up with the adder's registered sum.
module bist_expect_pipe
   import nibble_bist_pkg::*;
#(
   parameter int  LATENCY = 1,
   parameter type entry_t = pipe_entry_t
) (
   input  logic   clk,
   input  logic   clr,
   input  entry_t push,
   output entry_t tail
);

   entry_t stage [LATENCY];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < LATENCY; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= push;
         for (int i = 1; i < LATENCY; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign tail = stage[LATENCY-1];

endmodule

// File: rtl/nibble_adder_bist.sv
// Exhaustive self-test initiator for the registered nibble adder: sweeps every
// (a, b) pair, checks the returned sum and records the error count and first failure.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// RUN   | presenting vector vec_cnt to the adder
// DRAIN | operands zero, waiting LATENCY cycles for the last sums
// DONE  | results held, start restarts the sweep
module nibble_adder_bist
   import nibble_bist_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int LATENCY = 1,
   parameter int ERR_W   = DEF_ERR_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] dut_sum,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_RUN   = RUN;
   localparam logic [1:0] S_DRAIN = DRAIN;
   localparam logic [1:0] S_DONE  = DONE;
   localparam int         DW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   // Same layout as pipe_entry_t, sized for this instance's WIDTH.
   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] exp;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } entry_t;

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic [2*WIDTH-1:0] vec_cnt;
   logic [DW-1:0]      drain_cnt;
   logic               first_fail;
   logic               run_start;
   logic               mismatch;
   entry_t             push;
   entry_t             tail;

   assign op_a = (state == S_RUN) ? vec_cnt[2*WIDTH-1:WIDTH] : '0;
   assign op_b = (state == S_RUN) ? vec_cnt[WIDTH-1:0]       : '0;

   always_comb begin
      state_nxt = state;
      run_start = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               run_start = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (vec_cnt == '1) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drain_cnt == '0) begin
               state_nxt = S_DONE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      push       = '0;
      push.valid = (state == S_RUN);
      push.exp   = op_a + op_b;
      push.a     = op_a;
      push.b     = op_b;
   end

   assign mismatch = tail.valid && (dut_sum != tail.exp);

   bist_expect_pipe #(
      .LATENCY (LATENCY),
      .entry_t (entry_t)
   ) u_expect_pipe (
      .clk  (clk),
      .clr  (reset || run_start),
      .push (push),
      .tail (tail)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         vec_cnt    <= '0;
         drain_cnt  <= '0;
         first_fail <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_a     <= '0;
         fail_b     <= '0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
         done  <= (state_nxt == S_DONE);
         if (run_start) begin
            vec_cnt    <= '0;
            first_fail <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
         end else begin
            if (state == S_RUN) begin
               vec_cnt <= vec_cnt + (2*WIDTH)'(1);
               if (vec_cnt == '1) begin
                  drain_cnt <= DW'(LATENCY - 1);
               end
            end
            if (state == S_DRAIN && drain_cnt != '0) begin
               drain_cnt <= drain_cnt - DW'(1);
            end
            if (mismatch) begin
               if (err_count != '1) begin
                  err_count <= err_count + ERR_W'(1);
               end
               if (!first_fail) begin
                  first_fail <= 1'b1;
                  fail_a     <= tail.a;
                  fail_b     <= tail.b;
               end
            end
            // The final vector is judged on the same edge that enters DONE.
            if (state == S_DRAIN && state_nxt == S_DONE) begin
               pass <= (err_count == '0) && !mismatch;
            end
         end
      end
   end

endmodule

// File: tb/tb_nibble_adder_bist.sv
// Bench for nibble_adder_bist: faulty-adder models on two instances (latency 1 and 2),
// a cycle-indexed reference model and literal checks of the headline results.
module tb_nibble_adder_bist;

   localparam int LAT0 = 1;
   localparam int LAT1 = 2;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic       busy;
      logic       done;
      logic       pass;
      logic [7:0] err;
      logic [3:0] fa;
      logic [3:0] fb;
   } obs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset1, start1, reset2, start2;
   logic [3:0] op_a1, op_b1, sum1, fail_a1, fail_b1;
   logic [3:0] op_a2, op_b2, sum2, fail_a2, fail_b2, pipe2;
   logic       busy1, done1, pass1, busy2, done2, pass2;
   logic [7:0] err1, err2;

   int  n_pass  = 0;
   int  n_total = 0;
   bit  chk_en  = 1'b0;
   int  fault_mode = 0;
   bit  rnd_bad [256];
   bit  bad_cur [256];
   int  m_k [2];
   bit  m_bad [2][256];

   nibble_adder_bist #(.WIDTH(4), .LATENCY(LAT0), .ERR_W(8)) dut1 (
      .clk(clk), .reset(reset1), .start(start1), .op_a(op_a1), .op_b(op_b1),
      .dut_sum(sum1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_a(fail_a1), .fail_b(fail_b1)
   );

   nibble_adder_bist #(.WIDTH(4), .LATENCY(LAT1), .ERR_W(8)) dut2 (
      .clk(clk), .reset(reset2), .start(start2), .op_a(op_a2), .op_b(op_b2),
      .dut_sum(sum2), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2), .fail_a(fail_a2), .fail_b(fail_b2)
   );

   function automatic logic [3:0] fsum(int mode, logic [3:0] a, logic [3:0] b);
      logic [3:0] s;
      s = a + b;
      case (mode)
         1: s[0] = 1'b0;
         2: if (a == 4'd3 && b == 4'd4) s = 4'd0;
         3: s = ~s;
         4: if (rnd_bad[{a, b}]) s = s ^ 4'h5;
         default: ;
      endcase
      return s;
   endfunction

   // Faulty adder models: registered sum, one or two stages deep.
   always @(posedge clk) sum1 <= fsum(fault_mode, op_a1, op_b1);
   always @(posedge clk) begin
      pipe2 <= fsum(fault_mode, op_a2, op_b2);
      sum2  <= pipe2;
   end

   initial begin
      sum1 = '0; sum2 = '0; pipe2 = '0;
      m_k[0] = -1; m_k[1] = -1;
   end

   function automatic int lat_of(int n);
      return (n == 0) ? LAT0 : LAT1;
   endfunction

   task automatic set_mode(int mode);
      int a, b;
      fault_mode = mode;
      for (int i = 0; i < 256; i++) begin
         a = i / 16;
         b = i % 16;
         bad_cur[i] = (int'(fsum(mode, 4'(a), 4'(b))) != (a + b) % 16);
      end
   endtask

   // Reference model: k is the cycle index within a run (-1 = idle).
   task automatic model_step(int n, logic rst, logic st);
      int l;
      l = lat_of(n);
      if (rst) begin
         m_k[n] = -1;
      end else if ((m_k[n] < 0 || m_k[n] >= 256 + l) && st) begin
         m_k[n] = 0;
         for (int i = 0; i < 256; i++) m_bad[n][i] = bad_cur[i];
      end else if (m_k[n] >= 0 && m_k[n] < 256 + l) begin
         m_k[n] = m_k[n] + 1;
      end
   endtask

   always @(posedge clk) begin
      model_step(0, reset1, start1);
      model_step(1, reset2, start2);
   end

   function automatic obs_t expect_obs(int n);
      obs_t e;
      int k, l, seen, cnt, first;
      e = '0;
      k = m_k[n];
      l = lat_of(n);
      if (k < 0) return e;
      seen = (k >= 256 + l) ? 256 : k - l;
      if (seen < 0) seen = 0;
      cnt = 0;
      first = -1;
      for (int i = 0; i < seen; i++) begin
         if (m_bad[n][i]) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      e.err = 8'((cnt > 255) ? 255 : cnt);
      if (first >= 0) begin
         e.fa = 4'(first / 16);
         e.fb = 4'(first % 16);
      end
      if (k < 256) begin
         e.a = 4'(k / 16);
         e.b = 4'(k % 16);
         e.busy = 1'b1;
      end else if (k < 256 + l) begin
         e.busy = 1'b1;
      end else begin
         e.done = 1'b1;
         e.pass = (cnt == 0);
      end
      return e;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("cycle_lat1", {op_a1, op_b1, busy1, done1, pass1, err1, fail_a1, fail_b1},
               expect_obs(0));
         check("cycle_lat2", {op_a2, op_b2, busy2, done2, pass2, err2, fail_a2, fail_b2},
               expect_obs(1));
      end
   end

   task automatic set_start(int n, logic v);
      if (n == 0) start1 = v;
      else        start2 = v;
   endtask

   function automatic logic done_of(int n);
      return (n == 0) ? done1 : done2;
   endfunction

   // Starts a run and returns the RUN-cycle index at which done was first seen.
   task automatic run_bist(int n, bit poke50, output int c);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      set_start(n, 1'b1);
      @(negedge clk);
      set_start(n, 1'b0);
      c = 0;
      check("start_done_low", {63'd0, done_of(n)}, 64'd0);
      check("start_err_clr", (n == 0) ? err1 : err2, 64'd0);
      while (!done_of(n) && c < 400) begin
         @(negedge clk);
         c++;
         set_start(n, poke50 && c == 50);
      end
   endtask

   initial begin
      int c, dcnt, rcnt;
      reset1 = 1'b1; reset2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
      set_mode(0);
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("reset_outputs", {op_a1, op_b1, busy1, done1, pass1, err1, fail_a1, fail_b1}, 64'd0);
      reset1 = 1'b0;

      // Ideal adder, with a start pulse in the middle of RUN that must be ignored.
      run_bist(0, 1'b1, c);
      check("ideal_done_cycle", c, 257);
      check("ideal_pass", pass1, 1);
      check("ideal_err", err1, 0);
      check("ideal_fail_ab", {fail_a1, fail_b1}, 0);

      // Restart from DONE with sum bit 0 stuck low.
      set_mode(1);
      run_bist(0, 1'b0, c);
      check("stuck_done_cycle", c, 257);
      check("stuck_err", err1, 128);
      check("stuck_fail_ab", {fail_a1, fail_b1}, {4'd0, 4'd1});
      check("stuck_pass", pass1, 0);

      set_mode(2);
      run_bist(0, 1'b0, c);
      check("single_err", err1, 1);
      check("single_fail_ab", {fail_a1, fail_b1}, {4'd3, 4'd4});
      check("single_pass", pass1, 0);

      set_mode(3);
      run_bist(0, 1'b0, c);
      check("invert_err_sat", err1, 255);
      check("invert_fail_ab", {fail_a1, fail_b1}, 0);
      check("invert_pass", pass1, 0);

      // Random scattered faults.
      rcnt = 0;
      for (int i = 0; i < 256; i++) begin
         rnd_bad[i] = ($urandom_range(0, 15) == 0);
         if (rnd_bad[i]) rcnt++;
      end
      set_mode(4);
      run_bist(0, 1'b0, c);
      check("random_err", err1, (rcnt > 255) ? 255 : rcnt);
      check("random_pass", pass1, (rcnt == 0) ? 1 : 0);

      // Reset in RUN cycle 100: outputs clear next cycle, no done afterwards.
      set_mode(0);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int i = 0; i < 100; i++) @(negedge clk);
      check("pre_reset_busy", busy1, 1);
      reset1 = 1'b1;
      @(negedge clk);
      check("mid_reset_outputs", {op_a1, op_b1, busy1, done1, pass1, err1, fail_a1, fail_b1}, 0);
      reset1 = 1'b0;
      dcnt = 0;
      repeat (300) begin
         @(negedge clk);
         if (done1) dcnt++;
      end
      check("aborted_no_done", dcnt, 0);

      // Latency-2 instance with a matching adder model.
      reset2 = 1'b0;
      run_bist(1, 1'b0, c);
      check("lat2_done_cycle", c, 258);
      check("lat2_pass", pass2, 1);
      check("lat2_err", err2, 0);

      set_mode(1);
      run_bist(1, 1'b0, c);
      check("lat2_stuck_err", err2, 128);
      check("lat2_stuck_fail_ab", {fail_a2, fail_b2}, {4'd0, 4'd1});

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
